pattern_scan_ctrl: RTL and testbench

//  Front-end scheduler for the bit-serial 10110 Mealy pattern detector.

---
 rtl/pattern_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Round-robin front end for a bit-serial 10110 detector: grants one of two
// requesters, clears the detector, shifts the word MSB-first and returns the match count.
module pattern_scan_ctrl #(
  parameter int unsigned W       = 11,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DET_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  output logic             req1_ready,
  output logic             det_rst_o,
  output logic             det_d_o,
  output logic             det_valid_o,
  input  logic             det_pattern_i,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned DW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [W-1:0]     shift_q;
  logic [BW-1:0]    bit_q;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             last_q;
  logic             grant0, grant1;
  logic             count_en;

  // Tie goes to the requester not granted last; ready is held low while rst is asserted.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state == IDLE) & rst & grant0;
    req1_ready = (state == IDLE) & rst & grant1;
  end

  always_comb begin
    state_nx    = state;
    det_rst_o   = 1'b0;
    det_valid_o = 1'b0;
    det_d_o     = 1'b0;
    res_valid   = 1'b0;
    count_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_ready | req1_ready) state_nx = CLEAR;
      end
      CLEAR: begin
        det_rst_o = 1'b1;
        state_nx  = SHIFT;
      end
      SHIFT: begin
        det_valid_o = 1'b1;
        det_d_o     = shift_q[W-1];
        count_en    = 1'b1;
        if (bit_q == '0) state_nx = (DET_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        count_en = 1'b1;
        if (drain_q == '0) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign res_id    = id_q;
  assign res_count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            shift_q <= req0_data;
            id_q    <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (req1_ready) begin
            shift_q <= req1_data;
            id_q    <= 1'b1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: bit_q <= BW'(W - 1);
        SHIFT: begin
          shift_q <= {shift_q[W-2:0], 1'b0};
          bit_q   <= bit_q - 1'b1;
          if (bit_q == '0) drain_q <= DW'(DET_LAT - 1);
        end
        DRAIN: drain_q <= drain_q - 1'b1;
        default: ;
      endcase
      // Saturating count; pulses outside SHIFT/DRAIN never reach here.
      if (count_en && det_pattern_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: cycle model of the handshake/serial timing,
// behavioural 10110 detector, and a result scoreboard.
module tb_pattern_scan_ctrl;

  localparam int unsigned W       = 11;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned DET_LAT = 1;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [W-1:0]     req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             det_rst_o, det_d_o, det_valid_o, det_pattern_i;
  logic             res_valid, res_id, res_ready;
  logic [CNT_W-1:0] res_count;

  pattern_scan_ctrl #(.W(W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_rst_o(det_rst_o), .det_d_o(det_d_o), .det_valid_o(det_valid_o),
    .det_pattern_i(det_pattern_i),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-overlapping 10110 detector, one cycle from bit to pulse.
  logic [3:0] d_hist;
  logic [2:0] d_len;
  logic       det_pat_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_hist <= '0; d_len <= '0; det_pat_q <= 1'b0;
    end else if (det_rst_o) begin
      d_hist <= '0; d_len <= '0; det_pat_q <= 1'b0;
    end else if (det_valid_o) begin
      if (d_len >= 3'd4 && {d_hist, det_d_o} == 5'b10110) begin
        det_pat_q <= 1'b1; d_hist <= '0; d_len <= '0;
      end else begin
        det_pat_q <= 1'b0;
        d_hist    <= {d_hist[2:0], det_d_o};
        d_len     <= (d_len == 3'd4) ? 3'd4 : d_len + 3'd1;
      end
    end else begin
      det_pat_q <= 1'b0;
    end
  end

  int   stub_mode;  // 0 real detector, 1 pulse always, 2 pulse only outside SHIFT/DRAIN
  logic stub_q;
  assign det_pattern_i = (stub_mode == 0) ? det_pat_q : stub_q;

  int unsigned      total, bad;
  logic [CNT_W:0]   sb[$];
  logic             busy, m_last;
  int               m_cyc;
  logic [W-1:0]     m_word;
  int unsigned      nhs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_count(input logic [W-1:0] w);
    int unsigned hist, len, n;
    hist = 0; len = 0; n = 0;
    if (stub_mode == 1) n = W + DET_LAT;
    else if (stub_mode == 0) begin
      for (int i = W - 1; i >= 0; i--) begin
        hist = ((hist << 1) | w[i]) & 31;
        len++;
        if (len >= 5 && hist == 5'b10110) begin n++; hist = 0; len = 0; end
      end
    end
    if (n > CMAX) n = CMAX;
    return n[CNT_W-1:0];
  endfunction

  task automatic tick();
    logic eg0, eg1, ev, gid;
    logic [CNT_W:0] e;
    logic [W-1:0]   wd;
    int idx;
    case (stub_mode)
      1:       stub_q = 1'b1;
      2:       stub_q = !(busy && m_cyc >= 2 && m_cyc <= int'(W + 1 + DET_LAT));
      default: stub_q = 1'b0;
    endcase
    #1;
    eg0 = !busy && rst && req0_valid && (!req1_valid || m_last);
    eg1 = !busy && rst && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, eg0);
    chk("req1_ready", req1_ready, eg1);
    ev  = busy && m_cyc >= 2 && m_cyc <= int'(W + 1);
    idx = W + 1 - m_cyc;
    chk("det_rst_o", det_rst_o, busy && m_cyc == 1);
    chk("det_valid_o", det_valid_o, ev);
    chk("det_d_o", det_d_o, ev ? m_word[idx] : 1'b0);
    chk("res_valid", res_valid, busy && m_cyc >= int'(W + DET_LAT + 2));
    if (res_valid && sb.size() != 0) begin
      e = sb[0];
      chk("res_id", res_id, e[CNT_W]);
      chk("res_count", res_count, e[CNT_W-1:0]);
    end
    if (res_valid && res_ready) begin
      chk("sb_size", sb.size(), 1);
      if (sb.size() != 0) void'(sb.pop_front());
      busy = 1'b0;
    end
    if (eg0 || eg1) begin
      gid = eg1;
      wd  = eg1 ? req1_data : req0_data;
      sb.push_back({gid, exp_count(wd)});
      m_word = wd; busy = 1'b1; m_cyc = 0; m_last = gid; nhs++;
    end
    @(posedge clk);
    if (busy && rst) m_cyc++;
    #1;
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && (busy || sb.size() != 0); i++) tick();
    chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic hs_one(input logic which);
    int unsigned n0;
    n0 = nhs;
    if (which) req1_valid = 1'b1; else req0_valid = 1'b1;
    for (int i = 0; i < 60 && nhs == n0; i++) tick();
    if (which) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("hs_timeout", nhs - n0, 1);
  endtask

  initial begin
    int unsigned n0;
    total = 0; bad = 0; nhs = 0;
    busy = 1'b0; m_last = 1'b1; m_cyc = 0; m_word = '0;
    stub_mode = 0; stub_q = 1'b0;
    rst = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 11'b10110110110; req1_data = '0;

    // reset with both requesters pending, then the first tie goes to req0
    repeat (3) tick();
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_count", res_count, '0);
    rst = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(40);

    // continuous contention with shifting data on both ports
    req0_valid = 1'b1; req1_valid = 1'b1;
    n0 = nhs;
    for (int i = 0; i < 400 && nhs - n0 < 4; i++) begin
      req0_data = W'($urandom); req1_data = W'($urandom);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("alt_grants", nhs - n0, 4);
    drain(40);

    // saturation, then pulses only outside the counting window
    stub_mode = 1; req0_data = W'($urandom);
    hs_one(1'b0); drain(40);
    stub_mode = 2; req1_data = W'($urandom);
    hs_one(1'b1); drain(40);
    stub_mode = 0;

    // result backpressure with req1 waiting
    res_ready = 1'b0; req0_data = 11'b00101101011;
    hs_one(1'b0);
    req1_data = 11'b10110000000; req1_valid = 1'b1;
    repeat (W + DET_LAT + 2 + 20) tick();
    chk("bp_hold", res_valid, 1'b1);
    res_ready = 1'b1;
    n0 = nhs;
    tick();
    tick();
    chk("bp_next_grant", nhs - n0, 1);
    req1_valid = 1'b0;
    drain(40);

    // asynchronous reset in the middle of SHIFT
    req0_data = 11'b11111111111;
    hs_one(1'b0);
    for (int i = 0; i < 40 && m_cyc < 7; i++) tick();
    rst = 1'b0;
    #1;
    busy = 1'b0; m_last = 1'b1; sb.delete();
    chk("mid_rst_det_valid", det_valid_o, 1'b0);
    chk("mid_rst_det_d", det_d_o, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    req1_data = 11'b01011010110;
    hs_one(1'b1);
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
